// File: rtl/frame_len_monitor.sv
// Per-frame beat counter and length checker on a valid/ready/last stream.
// Reports each frame's length with runt/giant flags, SOF errors and wrap-around statistics.
module frame_len_monitor #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MIN_LEN = 4,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             rdy,
  input  logic             last,
  input  logic             sof,
  input  logic             clr,
  output logic             len_vld,
  output logic [LEN_W-1:0] len,
  output logic             runt,
  output logic             giant,
  output logic             sof_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [0:0] {StIdle, StRunning} state_e;

  localparam logic [LEN_W-1:0] LenMin = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LenSat = '1;

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_next;
  logic             beat;

  assign beat = vld & rdy;

  // Count this beat would produce: a new frame restarts at 1, otherwise saturate.
  always_comb begin
    cnt_next = LEN_W'(1);
    if (state_q == StRunning) begin
      cnt_next = (cnt_q == LenSat) ? cnt_q : cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_vld   <= 1'b0;
      len       <= '0;
      runt      <= 1'b0;
      giant     <= 1'b0;
      sof_err   <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      len_vld <= 1'b0;
      sof_err <= 1'b0;
      if (beat) begin
        cnt_q   <= cnt_next;
        sof_err <= (state_q == StIdle) ? ~sof : sof;
        if (last) begin
          state_q <= StIdle;
          len_vld <= 1'b1;
          len     <= cnt_next;
          runt    <= (cnt_next < LenMin);
          giant   <= (cnt_next > LenMax);
        end else begin
          state_q <= StRunning;
        end
      end
      // clr takes priority over a coincident statistics update.
      if (clr) begin
        frame_cnt <= '0;
        err_cnt   <= '0;
      end else if (len_vld) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (runt | giant) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_len_monitor.sv
// Scoreboard bench for frame_len_monitor: a wide instance (defaults) and a LEN_W=4 instance
// share one stream; expected reports and sof_err pulses are queued at drive time.
module tb_frame_len_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld = 1'b0, rdy = 1'b0, last = 1'b0, sof = 1'b0, clr = 1'b0;

  logic        len_vld_a, runt_a, giant_a, sof_err_a;
  logic [15:0] len_a;
  logic [31:0] frame_cnt_a, err_cnt_a;
  logic        len_vld_b, runt_b, giant_b, sof_err_b;
  logic [3:0]  len_b;
  logic [7:0]  frame_cnt_b, err_cnt_b;

  frame_len_monitor dut_a (
    .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .last(last), .sof(sof), .clr(clr),
    .len_vld(len_vld_a), .len(len_a), .runt(runt_a), .giant(giant_a), .sof_err(sof_err_a),
    .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a)
  );

  frame_len_monitor #(.LEN_W(4), .MIN_LEN(4), .MAX_LEN(12), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .vld(vld), .rdy(rdy), .last(last), .sof(sof), .clr(clr),
    .len_vld(len_vld_b), .len(len_b), .runt(runt_b), .giant(giant_b), .sof_err(sof_err_b),
    .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int len;
    bit runt;
    bit giant;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   sq_a[$];
  int   sq_b[$];

  int cyc = 0;
  int check_count = 0;
  int err_count = 0;

  // Reference state
  bit in_frame = 1'b0;
  int n_a = 0, n_b = 0;
  int frames_a = 0, errs_a = 0, frames_b = 0, errs_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint act, input longint exp);
    check_count++;
    if (act != exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_len(input int e);
    exp_t x;
    x.cyc = e; x.len = n_a; x.runt = (n_a < 4); x.giant = (n_a > 1518);
    q_a.push_back(x);
    frames_a++;
    if (x.runt || x.giant) errs_a++;
    x.len = n_b; x.runt = (n_b < 4); x.giant = (n_b > 12);
    q_b.push_back(x);
    frames_b++;
    if (x.runt || x.giant) errs_b++;
  endtask

  // One clock of stimulus; the reference model reacts to the handshake as it is driven.
  task automatic drive(input logic v, input logic r, input logic l, input logic s);
    int e;
    vld = v; rdy = r; last = l; sof = s;
    if (v && r) begin
      e = cyc + 1;
      if (!in_frame) begin
        n_a = 1; n_b = 1;
        if (!s) begin sq_a.push_back(e); sq_b.push_back(e); end
      end else begin
        if (n_a < 65535) n_a++;
        if (n_b < 15) n_b++;
        if (s) begin sq_a.push_back(e); sq_b.push_back(e); end
      end
      if (l) begin
        push_len(e);
        in_frame = 1'b0;
      end else begin
        in_frame = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // flip_idx: beat index whose sof value is inverted (-1 for none).
  task automatic send_frame(input int n, input int flip_idx);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, (i == n - 1), ((i == 0) ^ (i == flip_idx)));
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    frames_a = 0; errs_a = 0; frames_b = 0; errs_b = 0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_frame_cnt_a"}, frame_cnt_a, frames_a);
    chk({tag, "_err_cnt_a"}, err_cnt_a, errs_a);
    chk({tag, "_frame_cnt_b"}, frame_cnt_b, frames_b);
    chk({tag, "_err_cnt_b"}, err_cnt_b, errs_b);
  endtask

  exp_t m_a, m_b;
  int   s_a, s_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (len_vld_a) begin
        if (q_a.size() == 0) chk("len_vld_a_extra", len_vld_a, 0);
        else begin
          m_a = q_a.pop_front();
          chk("len_a_cycle", cyc, m_a.cyc);
          chk("len_a", len_a, m_a.len);
          chk("runt_a", runt_a, m_a.runt);
          chk("giant_a", giant_a, m_a.giant);
        end
      end
      if (len_vld_b) begin
        if (q_b.size() == 0) chk("len_vld_b_extra", len_vld_b, 0);
        else begin
          m_b = q_b.pop_front();
          chk("len_b_cycle", cyc, m_b.cyc);
          chk("len_b", len_b, m_b.len);
          chk("runt_b", runt_b, m_b.runt);
          chk("giant_b", giant_b, m_b.giant);
        end
      end
      if (sof_err_a) begin
        if (sq_a.size() == 0) chk("sof_err_a_extra", sof_err_a, 0);
        else begin
          s_a = sq_a.pop_front();
          chk("sof_err_a_cycle", cyc, s_a);
        end
      end
      if (sof_err_b) begin
        if (sq_b.size() == 0) chk("sof_err_b_extra", sof_err_b, 0);
        else begin
          s_b = sq_b.pop_front();
          chk("sof_err_b_cycle", cyc, s_b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", err_count,
             check_count);
    $fatal(1);
  end

  initial begin
    int beats;
    @(posedge clk);
    #1;
    chk("rst_len_vld", len_vld_a, 0);
    chk("rst_len", len_a, 0);
    chk("rst_runt", runt_a, 0);
    chk("rst_giant", giant_a, 0);
    chk("rst_sof_err", sof_err_a, 0);
    chk("rst_frame_cnt", frame_cnt_a, 0);
    chk("rst_err_cnt", err_cnt_a, 0);
    chk("rst_len_b", len_b, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 64-beat frame
    send_frame(64, -1);
    idle(3);
    chk_stats("t1");

    // 1, 3, 1519 back-to-back
    clr_pulse();
    chk_stats("clr");
    send_frame(1, -1);
    send_frame(3, -1);
    send_frame(1519, -1);
    idle(3);
    chk("t2_frames", frame_cnt_a, 3);
    chk("t2_errs", err_cnt_a, 3);
    chk_stats("t2");

    // 10 handshakes with rdy toggling and a vld gap
    beats = 0;
    for (int k = 0; k < 40 && beats < 10; k++) begin
      logic v, r;
      v = !(k == 5 || k == 6);
      r = (k % 2 == 0);
      drive(v, r, (beats == 9), (beats == 0));
      if (v && r) beats++;
    end
    chk("t3_beats", beats, 10);
    idle(3);
    chk_stats("t3");

    // sof missing on first beat, spurious sof on beat 5
    send_frame(8, 0);
    send_frame(8, 4);
    idle(3);
    chk_stats("t4");

    // reset on beat 20, then a 6-beat frame
    for (int i = 0; i < 19; i++) drive(1'b1, 1'b1, 1'b0, (i == 0));
    vld = 1'b1; rdy = 1'b1; last = 1'b0; sof = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    in_frame = 1'b0;
    frames_a = 0; errs_a = 0; frames_b = 0; errs_b = 0;
    vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send_frame(6, -1);
    idle(3);
    chk("t5_frame_cnt", frame_cnt_a, 1);
    chk_stats("t5");

    // 20-beat frame saturates the narrow counter; clr coincides with its len_vld
    send_frame(20, -1);
    chk("t6_len_vld_b", len_vld_b, 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    frames_a = 0; errs_a = 0; frames_b = 0; errs_b = 0;
    idle(2);
    chk_stats("t6");

    idle(2);
    chk("q_a_left", q_a.size(), 0);
    chk("q_b_left", q_b.size(), 0);
    chk("sq_a_left", sq_a.size(), 0);
    chk("sq_b_left", sq_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
